// File: rtl/dsp_mac_sequencer.sv
// Control sequencer for a DSP48A1 slice used as a multiply-accumulator.
// Streams operand beats, tracks them through the M/P stages, pulses done.
module dsp_mac_sequencer #(
  parameter int          LEN_W      = 8,
  parameter logic [7:0]  OPMODE_ACC = 8'h09
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [1:0]       tk;
  logic             beat;

  // abort suppresses the beat in the cycle it is raised
  assign beat = (state == S_FEED) && s_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rem   <= '0;
      tk    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rem   <= len;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            tk    <= '0;
            state <= S_ABORT;
          end else if (rem == '0) begin
            state <= S_DONE;
          end else begin
            state <= S_FEED;
          end
        end
        S_FEED: begin
          if (abort) begin
            tk    <= '0;
            state <= S_ABORT;
          end else begin
            tk <= {tk[0], beat};
            if (beat) begin
              rem <= rem - LEN_W'(1);
              if (rem == LEN_W'(1))
                state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            tk    <= '0;
            state <= S_ABORT;
          end else begin
            tk <= {tk[0], 1'b0};
            // tk goes all-zero on this edge once tk[0] is clear
            if (!tk[0])
              state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s_ready = (state == S_FEED);
  assign ce_ab   = beat;
  assign ce_m    = tk[0];
  assign ce_p    = tk[1];
  assign rst_p   = (state == S_CLEAR) || (state == S_ABORT);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign opmode  = busy ? OPMODE_ACC : 8'h00;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural slice model.
// Per-cycle output traces are compared against hand-computed masks.
module tb_dsp_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       s_valid;
  logic       s_ready;
  logic       ce_ab;
  logic       ce_m;
  logic       ce_p;
  logic       rst_p;
  logic [7:0] opmode;
  logic       busy;
  logic       done;

  logic [7:0]  a, b, ar, br;
  logic [15:0] m;
  logic [31:0] p;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(8), .OPMODE_ACC(8'h09)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
    .ce_ab(ce_ab), .ce_m(ce_m), .ce_p(ce_p), .rst_p(rst_p),
    .opmode(opmode), .busy(busy), .done(done)
  );

  // slice model: A/B -> M -> P, accumulate when OPMODE selects X=M, Z=P
  always @(posedge clk) begin
    if (ce_ab) begin
      ar <= a;
      br <= b;
    end
    if (ce_m) m <= ar * br;
    if (rst_p) p <= '0;
    else if (ce_p && opmode == 8'h09) p <= p + 32'(m);
  end

  typedef struct {
    logic [7:0]  n;
    logic [15:0] vp;
    logic [15:0] rp, rdy, ab, cm, cp, dn, bsy;
    logic [31:0] sum;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {s_ready, ce_ab, ce_m, ce_p, rst_p, busy, done, opmode};
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [15:0] rp, rdy, ab, cm, cp, dn, bsy;
    logic        opbad;
    rp = '0; rdy = '0; ab = '0; cm = '0; cp = '0; dn = '0; bsy = '0;
    opbad = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      start   = (c == 0);
      len     = v.n;
      s_valid = (c >= 2) ? v.vp[c-2] : 1'b0;
      a       = 8'(c + 1);
      b       = 8'(2 * c + 3);
      #1;
      rp[c]  = rst_p;
      rdy[c] = s_ready;
      ab[c]  = ce_ab;
      cm[c]  = ce_m;
      cp[c]  = ce_p;
      dn[c]  = done;
      bsy[c] = busy;
      if (opmode !== (v.bsy[c] ? 8'h09 : 8'h00)) opbad = 1'b1;
    end
    s_valid = 1'b0;
    chk($sformatf("v%0d rst_p", id), 32'(rp), 32'(v.rp));
    chk($sformatf("v%0d s_ready", id), 32'(rdy), 32'(v.rdy));
    chk($sformatf("v%0d ce_ab", id), 32'(ab), 32'(v.ab));
    chk($sformatf("v%0d ce_m", id), 32'(cm), 32'(v.cm));
    chk($sformatf("v%0d ce_p", id), 32'(cp), 32'(v.cp));
    chk($sformatf("v%0d done", id), 32'(dn), 32'(v.dn));
    chk($sformatf("v%0d busy", id), 32'(bsy), 32'(v.bsy));
    chk($sformatf("v%0d opmode", id), 32'(opbad), 32'd0);
    chk($sformatf("v%0d p_sum", id), p, v.sum);
  endtask

  initial begin
    logic seen;
    // operands per cycle c: a=c+1, b=2c+3
    tv[0] = '{8'd2, 16'hFFFF, 16'h0002, 16'h000C, 16'h000C,
              16'h0018, 16'h0030, 16'h0040, 16'h007E, 32'd57};
    tv[1] = '{8'd4, 16'hFFFF, 16'h0002, 16'h003C, 16'h003C,
              16'h0078, 16'h00F0, 16'h0100, 16'h01FE, 32'd190};
    tv[2] = '{8'd3, 16'hFFF9, 16'h0002, 16'h007C, 16'h0064,
              16'h00C8, 16'h0190, 16'h0200, 16'h03FE, 32'd204};
    tv[3] = '{8'd0, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000,
              16'h0000, 16'h0000, 16'h0004, 16'h0006, 32'd0};
    tv[4] = '{8'd1, 16'hFFFF, 16'h0002, 16'h0004, 16'h0004,
              16'h0008, 16'h0010, 16'h0020, 16'h003E, 32'd21};

    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    s_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    // reset mid-FEED after two beats
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start   = (c == 0);
      len     = 8'd5;
      s_valid = (c >= 2);
    end
    #1;
    chk("pre-rst busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst outs", 32'(outs()), 32'd0);
    @(negedge clk);
    chk("held rst outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    s_valid = 1'b0;
    chk("post-rst idle", 32'(seen), 32'd0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      p = 32'hDEAD_BEEF;
      run_vec(tv[i], i);
    end

    // abort in FEED after 2 of 6 beats; start while busy ignored
    @(negedge clk);
    start = 1'b1; len = 8'd6; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("busy start ce_ab", 32'(ce_ab), 32'd1);
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    #1;
    chk("abort cyc ce_ab", 32'(ce_ab), 32'd0);
    @(negedge clk);
    abort = 1'b0; start = 1'b1;
    #1;
    chk("abort rst_p", 32'(rst_p), 32'd1);
    chk("abort s_ready", 32'(s_ready), 32'd0);
    chk("abort ce_mp", 32'({ce_m, ce_p, busy}), 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("abort idle", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (done || busy || ce_ab || ce_m || ce_p) seen = 1'b1;
    end
    s_valid = 1'b0;
    chk("abort quiet", 32'(seen), 32'd0);

    // start+abort in IDLE: start wins; abort in DONE ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start wins", 32'({busy, rst_p}), 32'd3);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("done abort", 32'(done), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("after done", 32'({busy, done}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
